// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions used by the load/store unit:
//   - func3 width/sign codes for loads and stores
//   - lsu_state_t, the LSU FSM state encoding
//   - helpers that classify a request (illegal func3, misalignment) and
//     compute the forced-aligned lane offset
// No ports (package).
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } lsu_state_t;

    // Encodings with no RV32I meaning: loads 011/110/111, stores 011 and up.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 > F3_W);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Half accesses need an even address, word accesses a 4-byte boundary.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Drop the low offset bits that a half/word access cannot use.
    function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return {off[1], 1'b0};
            2'b10:   return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Bundles the execute-stage request/response handshake and the data RAM
// req/ack port of the load/store unit.
//   request : req_valid, req_ready, req_we, req_func3, req_addr, req_wdata
//   response: resp_valid, resp_rdata, resp_err
//   RAM     : mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_rdata, mem_ack
// Modports: slave  = the LSU itself
//           master = the surroundings (execute stage + RAM)
// ---------------------------------------------------------------------------
interface lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_func3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane.sv
// ---------------------------------------------------------------------------
// lsu_lane
// Purely combinational byte-lane logic of the LSU.
//   Store side: st_we, st_func3, st_offset, rs2 -> be, wdata
//     (loads get be=1111 and wdata=0)
//   Load side : ld_func3, ld_offset, word -> rdata (lane shifted to bit 0,
//     sign- or zero-extended)
// Only DATA_WIDTH=32 is meaningful (four byte lanes).
// ---------------------------------------------------------------------------
module lsu_lane
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  st_we,
    input  logic [2:0]            st_func3,
    input  logic [1:0]            st_offset,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            ld_func3,
    input  logic [1:0]            ld_offset,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [7:0]  ld_bytes [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign ld_bytes[gi] = word[8*gi +: 8];
    end

    assign ld_byte = ld_bytes[ld_offset];
    assign ld_half = ld_offset[1] ? word[31:16] : word[15:0];

    // Store data is replicated across all lanes so the RAM only needs the
    // byte enables to pick the right bytes.
    always_comb begin
        be    = 4'b1111;
        wdata = '0;
        if (st_we) begin
            case (st_func3)
                F3_B: begin
                    be    = 4'b0001 << st_offset;
                    wdata = {4{rs2[7:0]}};
                end
                F3_H: begin
                    be    = 4'b0011 << st_offset;
                    wdata = {2{rs2[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = rs2;
                end
            endcase
        end
    end

    always_comb begin
        rdata = word;
        case (ld_func3)
            F3_B:    rdata = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            F3_BU:   rdata = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            F3_H:    rdata = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            F3_HU:   rdata = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
// RV32I load/store unit: takes one request from execute, drives a
// word-addressed data RAM with byte enables over req/ack, and returns
// aligned, extended load data with a one-cycle resp_valid pulse.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - lsu_if.slave: request handshake, response, RAM port
// Build option:
//   LSU_MISALIGN_TRAP_EN defined   -> misaligned half/word access is rejected
//                                     with resp_err and no RAM access
//   LSU_MISALIGN_TRAP_EN undefined -> misaligned access is forced aligned
// ---------------------------------------------------------------------------
module lsu
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30
) (
    input  logic   clk,
    input  logic   rst,
    lsu_if.slave   bus
);

    lsu_state_t            state_reg;
    logic                  we_reg;
    logic [2:0]            func3_reg;
    logic [1:0]            offset_reg;
    logic                  resp_valid_reg;
    logic                  resp_err_reg;
    logic [DATA_WIDTH-1:0] resp_rdata_reg;
    logic                  mem_req_reg;
    logic                  mem_we_reg;
    logic [3:0]            mem_be_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;

    logic                  req_bad;
    logic [1:0]            eff_offset;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] ld_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_bad    = f3_illegal(bus.req_we, bus.req_func3)
                      || misaligned(bus.req_func3, bus.req_addr[1:0]);
    assign eff_offset = bus.req_addr[1:0];
`else
    assign req_bad    = f3_illegal(bus.req_we, bus.req_func3);
    assign eff_offset = align_offset(bus.req_func3, bus.req_addr[1:0]);
`endif

    // Store lanes come from the live request (registered on accept); load
    // extraction uses the registered func3/offset against the RAM word.
    lsu_lane #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .st_we     (bus.req_we),
        .st_func3  (bus.req_func3),
        .st_offset (eff_offset),
        .rs2       (bus.req_wdata),
        .be        (st_be),
        .wdata     (st_wdata),
        .ld_func3  (func3_reg),
        .ld_offset (offset_reg),
        .word      (bus.mem_rdata),
        .rdata     (ld_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            func3_reg      <= 3'b000;
            offset_reg     <= 2'b00;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= 4'b0000;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    resp_valid_reg <= 1'b0;
                    if (bus.req_valid) begin
                        we_reg     <= bus.req_we;
                        func3_reg  <= bus.req_func3;
                        offset_reg <= eff_offset;
                        if (req_bad) begin
                            // Rejected requests never touch the RAM.
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= '0;
                            state_reg      <= RESP;
                        end else begin
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= bus.req_we;
                            mem_be_reg    <= st_be;
                            mem_addr_reg  <= bus.req_addr[ADDR_WIDTH+1:2];
                            mem_wdata_reg <= st_wdata;
                            resp_err_reg  <= 1'b0;
                            state_reg     <= MEM;
                        end
                    end
                end
                MEM: begin
                    // RAM-side outputs stay frozen until the ack arrives.
                    if (bus.mem_ack) begin
                        mem_req_reg    <= 1'b0;
                        mem_we_reg     <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b0;
                        resp_rdata_reg <= we_reg ? '0 : ld_rdata;
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    // Leaving RESP unconditionally means a held ack cannot
                    // produce a second response.
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_be     = mem_be_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;

endmodule
